// File: rtl/pio_spi_host.sv
// Host sequencer for the pio block: loads an SPI program, configures one state machine,
// then runs byte transfers as PUSH / wait / PULL. Optional macro: PIO_SPI_HOST_TIMEOUT_EN.
module pio_spi_host #(
  parameter int MINDEX  = 0,
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        prog_we,
  input  logic [4:0]  prog_addr,
  input  logic [15:0] prog_data,
  input  logic [5:0]  cfg_plen,
  input  logic [23:0] cfg_div,
  input  logic [31:0] cfg_grps,
  input  logic [31:0] cfg_exec,
  input  logic [31:0] cfg_shift,
  input  logic        start,
  output logic        cfg_done,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        err,
  output logic [3:0]  action,
  output logic [4:0]  index,
  output logic [1:0]  mindex,
  output logic [31:0] din,
  input  logic [31:0] dout,
  input  logic [3:0]  tx_full,
  input  logic [3:0]  rx_empty
);

  localparam logic [1:0] MI = MINDEX[1:0];

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LOAD    = 4'd1;
  localparam logic [3:0] S_PEND    = 4'd2;
  localparam logic [3:0] S_DIV     = 4'd3;
  localparam logic [3:0] S_GRPS    = 4'd4;
  localparam logic [3:0] S_SHIFT   = 4'd5;
  localparam logic [3:0] S_EN      = 4'd6;
  localparam logic [3:0] S_READY   = 4'd7;
  localparam logic [3:0] S_PUSH    = 4'd8;
  localparam logic [3:0] S_WAIT_RX = 4'd9;
  localparam logic [3:0] S_PULL    = 4'd10;
  localparam logic [3:0] S_CAPTURE = 4'd11;

  localparam logic [3:0] ACT_NONE  = 4'd0;
  localparam logic [3:0] ACT_INSTR = 4'd1;
  localparam logic [3:0] ACT_PEND  = 4'd2;
  localparam logic [3:0] ACT_PULL  = 4'd3;
  localparam logic [3:0] ACT_PUSH  = 4'd4;
  localparam logic [3:0] ACT_GRPS  = 4'd5;
  localparam logic [3:0] ACT_EN    = 4'd6;
  localparam logic [3:0] ACT_DIV   = 4'd7;
  localparam logic [3:0] ACT_SHIFT = 4'd10;

  logic [15:0] store [32];
  logic [3:0]  state;
  logic        gap;
  logic [4:0]  idx;
  logic [7:0]  tx_byte;
  logic [5:0]  plen_eff;
  logic        last_instr;
  logic [3:0]  cfg_act;
  logic [3:0]  cfg_next;
  logic [31:0] cfg_din;
  logic        unused_bits;

  assign mindex = MI;

  // NOTE: the instruction store carries no reset; it is plain RAM and keeps its program across resets.
  always_ff @(posedge clk) begin
    if (prog_we) store[prog_addr] <= prog_data;
  end

  assign plen_eff   = (cfg_plen == 6'd0) ? 6'd1 : cfg_plen;
  assign last_instr = ({1'b0, idx} == plen_eff - 6'd1) || (idx == 5'd31);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cfg_act  = ACT_NONE;
    cfg_din  = 32'h0;
    cfg_next = S_IDLE;
    case (state)
      S_PEND:  begin cfg_act = ACT_PEND;  cfg_din = cfg_exec;        cfg_next = S_DIV;   end
      S_DIV:   begin cfg_act = ACT_DIV;   cfg_din = {8'h0, cfg_div}; cfg_next = S_GRPS;  end
      S_GRPS:  begin cfg_act = ACT_GRPS;  cfg_din = cfg_grps;        cfg_next = S_SHIFT; end
      S_SHIFT: begin cfg_act = ACT_SHIFT; cfg_din = cfg_shift;       cfg_next = S_EN;    end
      S_EN:    begin cfg_act = ACT_EN;    cfg_din = 32'h1;           cfg_next = S_READY; end
      default: ;
    endcase
  end

`ifdef PIO_SPI_HOST_TIMEOUT_EN
  logic [15:0] wait_cnt;
  assign unused_bits = ^{dout[31:8], tx_full, rx_empty};
`else
  assign err         = 1'b0;
  assign unused_bits = ^{dout[31:8], tx_full, rx_empty, TIMEOUT[0]};
`endif

  // NOTE: all state and registered outputs use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      gap      <= 1'b0;
      idx      <= 5'd0;
      tx_byte  <= 8'h0;
      action   <= ACT_NONE;
      index    <= 5'd0;
      din      <= 32'h0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h0;
      cfg_done <= 1'b0;
`ifdef PIO_SPI_HOST_TIMEOUT_EN
      wait_cnt <= 16'd0;
      err      <= 1'b0;
`endif
    end else begin
      action   <= ACT_NONE;
      rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            gap   <= 1'b0;
            idx   <= 5'd0;
          end
        end
        S_LOAD: begin
          if (!gap) begin
            action <= ACT_INSTR;
            index  <= idx;
            din    <= {16'h0, store[idx]};
            gap    <= 1'b1;
          end else begin
            gap <= 1'b0;
            if (last_instr) state <= S_PEND;
            else            idx   <= idx + 5'd1;
          end
        end
        S_PEND, S_DIV, S_GRPS, S_SHIFT, S_EN: begin
          // Each config action is followed by one NONE cycle before moving on.
          if (!gap) begin
            action <= cfg_act;
            din    <= cfg_din;
            gap    <= 1'b1;
          end else begin
            gap   <= 1'b0;
            state <= cfg_next;
            if (cfg_next == S_READY) begin
              tx_ready <= 1'b1;
              cfg_done <= 1'b1;
            end
          end
        end
        S_READY: begin
          if (tx_valid) begin
            tx_byte  <= tx_data;
            tx_ready <= 1'b0;
            state    <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (!tx_full[MI]) begin
            action <= ACT_PUSH;
            din    <= {tx_byte, 24'h0};
            state  <= S_WAIT_RX;
`ifdef PIO_SPI_HOST_TIMEOUT_EN
            wait_cnt <= 16'd0;
`endif
          end
        end
        S_WAIT_RX: begin
`ifdef PIO_SPI_HOST_TIMEOUT_EN
          wait_cnt <= wait_cnt + 16'd1;
`endif
          // The first WAIT_RX cycle still shows PUSH, so PULL waits for a NONE cycle.
          if (!rx_empty[MI] && action == ACT_NONE) begin
            action <= ACT_PULL;
            state  <= S_PULL;
          end
`ifdef PIO_SPI_HOST_TIMEOUT_EN
          else if (rx_empty[MI] && wait_cnt == 16'(TIMEOUT - 1)) begin
            err      <= 1'b1;
            tx_ready <= 1'b1;
            state    <= S_READY;
          end
`endif
        end
        S_PULL: state <= S_CAPTURE;
        S_CAPTURE: begin
          rx_data  <= dout[7:0];
          rx_valid <= 1'b1;
          tx_ready <= 1'b1;
          state    <= S_READY;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_spi_host.sv
// Bench for pio_spi_host: a small pio model loops pushed bytes back; a scoreboard queue
// holds the expected action stream and received bytes.
module tb_pio_spi_host;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        prog_we = 1'b0;
  logic [4:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [5:0]  cfg_plen = 6'd2;
  logic [23:0] cfg_div = 24'h000C80;
  logic [31:0] cfg_grps = 32'h20100001;
  logic [31:0] cfg_exec = 32'h00001000;
  logic [31:0] cfg_shift = 32'h10830000;
  logic        start = 1'b0;
  logic        cfg_done;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  tx_data = '0;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        err;
  logic [3:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din;
  logic [31:0] dout = '0;
  logic [3:0]  tx_full;
  logic [3:0]  rx_empty;

  always #5 clk = ~clk;

  pio_spi_host #(.MINDEX(0), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .cfg_plen(cfg_plen), .cfg_div(cfg_div), .cfg_grps(cfg_grps), .cfg_exec(cfg_exec),
    .cfg_shift(cfg_shift), .start(start), .cfg_done(cfg_done), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data), .err(err),
    .action(action), .index(index), .mindex(mindex), .din(din), .dout(dout),
    .tx_full(tx_full), .rx_empty(rx_empty)
  );

  int errors = 0;
  int checks = 0;

  localparam logic [15:0] W0 = 16'h6008;
  localparam logic [15:0] W1 = 16'h4001;

  // pio model: a pushed byte shows up in the RX slot 3 cycles later; PULL returns it on dout.
  logic       full_force = 1'b0;
  logic       loop_en = 1'b1;
  logic       slot = 1'b0;
  logic [7:0] slot_byte = '0;
  int         lat = 0;

  assign tx_full  = {3'b111, full_force};
  assign rx_empty = {3'b000, ~slot};

  always @(posedge clk) begin
    if (action == 4'd4 && loop_en) begin
      slot_byte <= din[31:24];
      lat       <= 3;
    end else if (lat != 0) begin
      lat <= lat - 1;
      if (lat == 1) slot <= 1'b1;
    end
    if (action == 4'd3) begin
      dout <= {24'h5A5A5A, slot_byte};
      slot <= 1'b0;
    end
  end

  typedef struct {
    logic [3:0]  act;
    logic [4:0]  idx;
    logic [31:0] din;
    bit          chk_din;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rx_q[$];
  exp_t       e;
  logic [3:0] prev_act = 4'd0;
  logic [3:0] last_act = 4'd0;

  task automatic expect_act(input logic [3:0] a, input logic [4:0] i, input logic [31:0] d,
                            input bit chk);
    exp_t x;
    x.act = a; x.idx = i; x.din = d; x.chk_din = chk;
    exp_q.push_back(x);
  endtask

  // Scoreboard: every non-NONE action is matched against the front of the expected queue.
  always @(negedge clk) begin
    if (reset) begin
      if (action != 4'd0) begin
        checks++;
        last_act = action;
        if (prev_act != 4'd0) begin
          errors++;
          $display("FAIL action_gap: action %0d directly after %0d, required NONE between", action, prev_act);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_action: got action=%0d din=%h, required no action", action, din);
        end else begin
          e = exp_q.pop_front();
          if (action !== e.act || (e.act == 4'd1 && index !== e.idx) || (e.chk_din && din !== e.din)) begin
            errors++;
            $display("FAIL action_stream: got act=%0d idx=%0d din=%h, required act=%0d idx=%0d din=%h",
                     action, index, din, e.act, e.idx, e.din);
          end
        end
      end
      prev_act = action;
    end else begin
      prev_act = 4'd0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (action !== 4'd0 || index !== 5'd0 || din !== 32'h0 || tx_ready !== 1'b0 ||
        rx_valid !== 1'b0 || rx_data !== 8'h0 || cfg_done !== 1'b0 || err !== 1'b0 || mindex !== 2'd0) begin
      errors++;
      $display("FAIL %s: act=%0d idx=%0d din=%h rdy=%b rxv=%b rxd=%h done=%b err=%b, required all zero",
               tag, action, index, din, tx_ready, rx_valid, rx_data, cfg_done, err);
    end
  endtask

  task automatic run_config(input logic [5:0] plen, input bit inject);
    int n;
    cfg_plen = plen;
    expect_act(4'd1, 5'd0, {16'h0, W0}, 1'b1);
    if (plen == 6'd2) expect_act(4'd1, 5'd1, {16'h0, W1}, 1'b1);
    expect_act(4'd2, 5'd0, cfg_exec, 1'b1);
    expect_act(4'd7, 5'd0, {8'h0, cfg_div}, 1'b1);
    expect_act(4'd5, 5'd0, cfg_grps, 1'b1);
    expect_act(4'd10, 5'd0, cfg_shift, 1'b1);
    expect_act(4'd6, 5'd0, 32'h1, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!cfg_done && n < 60) begin
      @(negedge clk);
      if (inject && n == 3) begin start = 1'b1; tx_valid = 1'b1; tx_data = 8'h77; end
      if (n == 4) begin start = 1'b0; tx_valid = 1'b0; end
      n++;
    end
    checks++;
    if (!cfg_done || last_act !== 4'd6 || exp_q.size() != 0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL config_done: done=%b last_act=%0d pending=%0d rdy=%b, required 1/6/0/1",
               cfg_done, last_act, exp_q.size(), tx_ready);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!tx_ready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!tx_ready) begin
      errors++;
      $display("FAIL %s: tx_ready=%b after %0d cycles, required 1", tag, tx_ready, n);
    end
  endtask

  task automatic wait_rx(input string tag);
    int n = 0;
    logic [7:0] want;
    while (!rx_valid && n < 100) begin @(negedge clk); n++; end
    want = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== want) begin
      errors++;
      $display("FAIL %s: rx_valid=%b rx_data=%h, required 1 and %h", tag, rx_valid, rx_data, want);
    end
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== want || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_pulse: rx_valid=%b rx_data=%h rdy=%b, required 0, %h held, 1",
               tag, rx_valid, rx_data, tx_ready, want);
    end
  endtask

  task automatic handshake(input logic [7:0] b, input bit expect_pull);
    expect_act(4'd4, 5'd0, {b, 24'h0}, 1'b1);
    if (expect_pull) begin
      expect_act(4'd3, 5'd0, 32'h0, 1'b0);
      rx_q.push_back(b);
    end
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    for (int i = 0; i < 2; i++) begin
      prog_we = 1'b1; prog_addr = 5'(i); prog_data = (i == 0) ? W0 : W1;
      @(negedge clk);
    end
    prog_we = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_config();
    run_config(6'd2, 1'b0);
  endtask

  task automatic test_transfer();
    logic [7:0] pats [4] = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
    foreach (pats[i]) begin
      wait_ready("xfer_ready");
      handshake(pats[i], 1'b1);
      wait_rx("xfer_rx");
    end
  endtask

  task automatic test_back_pressure();
    wait_ready("bp_ready");
    full_force = 1'b1;
    tx_valid = 1'b1; tx_data = 8'h96;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (action !== 4'd0 || tx_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d action=%0d rdy=%b, required 0/0", i, action, tx_ready);
      end
    end
    expect_act(4'd4, 5'd0, 32'h96000000, 1'b1);
    expect_act(4'd3, 5'd0, 32'h0, 1'b0);
    rx_q.push_back(8'h96);
    full_force = 1'b0;
    @(negedge clk);
    checks++;
    if (action !== 4'd4) begin
      errors++;
      $display("FAIL bp_release: action=%0d the cycle after release, required 4", action);
    end
    wait_rx("bp_rx");
  endtask

  task automatic test_mid_reset();
    int n = 0;
    loop_en = 1'b0;
    wait_ready("mr_ready");
    handshake(8'h81, 1'b0);
    while (action != 4'd4 && n < 20) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    reset = 1'b1;
    loop_en = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_push: %0d expected actions still pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_ignored_inputs();
    run_config(6'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (action !== 4'd0 || tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL ignored_inputs: cycle %0d action=%0d rdy=%b, required 0/1", i, action, tx_ready);
      end
    end
    handshake(8'h5E, 1'b1);
    wait_rx("reconfig_rx");
  endtask

  task automatic test_timeout();
    int n = 0;
    loop_en = 1'b0;
    wait_ready("to_ready");
    handshake(8'hC3, 1'b0);
    while (action != 4'd4 && n < 20) begin @(negedge clk); n++; end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k < 20) begin
        checks++;
        if (err !== 1'b0 || tx_ready !== 1'b0) begin
          errors++;
          $display("FAIL timeout_early: %0d cycles in WAIT_RX err=%b rdy=%b, required 0/0", k, err, tx_ready);
        end
      end else begin
        checks++;
        if (err !== 1'b1 || tx_ready !== 1'b1 || rx_valid !== 1'b0) begin
          errors++;
          $display("FAIL timeout_fire: err=%b rdy=%b rxv=%b, required 1/1/0", err, tx_ready, rx_valid);
        end
      end
    end
    loop_en = 1'b1;
    handshake(8'h42, 1'b1);
    wait_rx("after_timeout_rx");
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b after further transfer, required 1", err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_config();
    test_transfer();
    test_back_pressure();
    test_mid_reset();
    test_ignored_inputs();
`ifdef PIO_SPI_HOST_TIMEOUT_EN
    test_timeout();
`endif
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d actions and %0d bytes pending, required 0/0",
               exp_q.size(), rx_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
